// File: rtl/bcd_score_counter_pkg.sv
// score_pkg: shared digit width, BCD digit type and digit operation codes for the score counter
package score_pkg;
  localparam int DIGIT_W = 4;
  typedef logic [DIGIT_W-1:0] bcd_t;
  localparam bcd_t BCD_MAX = 4'd9;
  typedef enum logic [1:0] {OP_HOLD, OP_INC, OP_DEC, OP_CLR} score_op_t;
endpackage

// File: rtl/bcd_score_counter_if.sv
// bcd_score_counter_if: game-side requests (incr, decr, clear) and score/hiscore/flag outputs
// master drives the requests and observes the outputs; slave is the counter
interface bcd_score_counter_if #(parameter int NUM_DIGITS = 3);
  logic incr, decr, clear;
  logic [4*NUM_DIGITS-1:0] score, hiscore;
  logic at_max, wrap, new_high;
  modport master(output incr, decr, clear, input score, hiscore, at_max, wrap, new_high);
  modport slave(input incr, decr, clear, output score, hiscore, at_max, wrap, new_high);
endinterface

// File: rtl/bcd_score_counter_digit.sv
// bcd_digit: one BCD digit register stepped by op when its carry/borrow input is set
// ports: clk, reset, op (shared digit op), cin (carry or borrow from the digit below,
// tied high on the LS digit), digit, carry_out (9 rolling to 0), borrow_out (0 rolling to 9)
module bcd_digit import score_pkg::*; (
  input  logic      clk,
  input  logic      reset,
  input  score_op_t op,
  input  logic      cin,
  output bcd_t      digit,
  output logic      carry_out,
  output logic      borrow_out
);
  bcd_t nxt;
  assign carry_out = cin && op == OP_INC && digit == BCD_MAX;
  assign borrow_out = cin && op == OP_DEC && digit == 4'd0;
  always_comb
    nxt = op == OP_CLR ? 4'd0
        : !cin ? digit
        : op == OP_INC ? (carry_out ? 4'd0 : digit + 4'd1)
        : op == OP_DEC ? (borrow_out ? BCD_MAX : digit - 4'd1)
        : digit;
  always_ff @(posedge clk)
    digit <= reset ? 4'd0 : nxt;
endmodule

// File: rtl/bcd_score_counter.sv
// bcd_score_counter: packed-BCD score counter with floor, saturate/wrap and high-score tracking
// ports: clk, reset (sync, active-high), bus (slave): incr/decr/clear in; score, hiscore,
// at_max, wrap, new_high out
module bcd_score_counter import score_pkg::*; #(
  parameter int NUM_DIGITS  = 3,
  parameter bit SATURATE    = 1'b1,
  parameter bit EDGE_DETECT = 1'b1
) (
  input logic clk,
  input logic reset,
  bcd_score_counter_if.slave bus
);
  localparam int W = DIGIT_W * NUM_DIGITS;
  localparam logic [W-1:0] MAX_SCORE = {NUM_DIGITS{BCD_MAX}};
  logic incr_d, decr_d, inc_ev, dec_ev, wrap, new_high, at_max;
  logic [W-1:0] score, hiscore;
  logic [NUM_DIGITS:0] ch;
  score_op_t op;
  assign inc_ev = bus.incr & ~(incr_d & EDGE_DETECT);
  assign dec_ev = bus.decr & ~(decr_d & EDGE_DETECT);
  assign at_max = score == MAX_SCORE;
  // saturation and the zero floor both turn the request into a hold
  always_comb
    op = bus.clear ? OP_CLR
       : inc_ev && dec_ev ? OP_HOLD
       : inc_ev ? (at_max && SATURATE ? OP_HOLD : OP_INC)
       : dec_ev ? (score == '0 ? OP_HOLD : OP_DEC)
       : OP_HOLD;
  assign ch[0] = 1'b1;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic cry, brw;
    bcd_digit u_digit (
      .clk       (clk),
      .reset     (reset),
      .op        (op),
      .cin       (ch[i]),
      .digit     (score[DIGIT_W*i +: DIGIT_W]),
      .carry_out (cry),
      .borrow_out(brw)
    );
    assign ch[i+1] = cry | brw;
  end
  // a chain that runs out of the top digit on an increment is the wrap from all nines
  always_ff @(posedge clk)
    if (reset) begin
      incr_d   <= 1'b0;
      decr_d   <= 1'b0;
      wrap     <= 1'b0;
      new_high <= 1'b0;
      hiscore  <= '0;
    end else begin
      incr_d   <= bus.incr;
      decr_d   <= bus.decr;
      wrap     <= ch[NUM_DIGITS] && op == OP_INC;
      new_high <= !bus.clear && (new_high || score > hiscore);
      if (score > hiscore) hiscore <= score;
    end
  assign bus.score    = score;
  assign bus.hiscore  = hiscore;
  assign bus.at_max   = at_max;
  assign bus.wrap     = wrap;
  assign bus.new_high = new_high;
endmodule

// File: tb/tb_bcd_score_counter.sv
// tb_bcd_score_counter: three counter configurations driven in lockstep, checked by a scoreboard
module tb_bcd_score_counter;
  logic clk = 1'b0, reset = 1'b1, incr = 1'b0, decr = 1'b0, clear = 1'b0;
  always #5 clk = ~clk;
  // dut0: saturate + edge detect, dut1: saturate + level, dut2: wrap + edge detect
  bcd_score_counter_if #(3) bus0(), bus1(), bus2();
  bcd_score_counter #(.NUM_DIGITS(3), .SATURATE(1'b1), .EDGE_DETECT(1'b1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  bcd_score_counter #(.NUM_DIGITS(3), .SATURATE(1'b1), .EDGE_DETECT(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  bcd_score_counter #(.NUM_DIGITS(3), .SATURATE(1'b0), .EDGE_DETECT(1'b1)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
  assign bus0.incr = incr;
  assign bus0.decr = decr;
  assign bus0.clear = clear;
  assign bus1.incr = incr;
  assign bus1.decr = decr;
  assign bus1.clear = clear;
  assign bus2.incr = incr;
  assign bus2.decr = decr;
  assign bus2.clear = clear;
  typedef struct packed {
    logic [11:0] score;
    logic [11:0] hiscore;
    logic        at_max;
    logic        wrap;
    logic        new_high;
  } obs_t;
  typedef obs_t [2:0] obs3_t;
  obs3_t exp_q[$];
  obs3_t act;
  assign act[0] = {bus0.score, bus0.hiscore, bus0.at_max, bus0.wrap, bus0.new_high};
  assign act[1] = {bus1.score, bus1.hiscore, bus1.at_max, bus1.wrap, bus1.new_high};
  assign act[2] = {bus2.score, bus2.hiscore, bus2.at_max, bus2.wrap, bus2.new_high};
  int m_sc[3], m_hi[3];
  bit m_nh[3], m_wr[3], m_id[3], m_dd[3];
  int n_chk = 0, n_fail = 0;
  function automatic logic [11:0] to_bcd(int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction
  // reference: plain integer score, one update per applied input cycle
  task automatic cyc(bit i, bit d, bit c, bit r);
    obs3_t e;
    @(negedge clk);
    incr = i;
    decr = d;
    clear = c;
    reset = r;
    for (int k = 0; k < 3; k++) begin
      bit sat, ed, ie, de, gt;
      sat = k != 2;
      ed = k != 1;
      ie = i && !(ed && m_id[k]);
      de = d && !(ed && m_dd[k]);
      if (r) begin
        m_sc[k] = 0;
        m_hi[k] = 0;
        m_nh[k] = 0;
        m_wr[k] = 0;
        m_id[k] = 0;
        m_dd[k] = 0;
      end else begin
        gt = m_sc[k] > m_hi[k];
        m_wr[k] = !c && ie && !de && m_sc[k] == 999 && !sat;
        m_nh[k] = !c && (gt || m_nh[k]);
        if (gt) m_hi[k] = m_sc[k];
        if (c) m_sc[k] = 0;
        else if (ie && de) m_sc[k] = m_sc[k];
        else if (ie) m_sc[k] = m_sc[k] == 999 ? (sat ? 999 : 0) : m_sc[k] + 1;
        else if (de && m_sc[k] > 0) m_sc[k] = m_sc[k] - 1;
        m_id[k] = i;
        m_dd[k] = d;
      end
      e[k] = {to_bcd(m_sc[k]), to_bcd(m_hi[k]), m_sc[k] == 999, m_wr[k], m_nh[k]};
    end
    exp_q.push_back(e);
  endtask
  task automatic idle(int n);
    repeat (n) cyc(0, 0, 0, 0);
  endtask
  task automatic pulse_inc(int n);
    repeat (n) begin
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
    end
  endtask
  task automatic pulse_dec(int n);
    repeat (n) begin
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 0);
    end
  endtask
  task automatic chk(string nm, int k, logic [11:0] a, logic [11:0] x);
    n_chk++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s dut%0d at %0t: got %h expected %h", nm, k, $time, a, x);
    end
  endtask
  always @(posedge clk) begin
    obs3_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int k = 0; k < 3; k++) begin
        chk("score", k, act[k].score, e[k].score);
        chk("hiscore", k, act[k].hiscore, e[k].hiscore);
        chk("at_max", k, 12'(act[k].at_max), 12'(e[k].at_max));
        chk("wrap", k, 12'(act[k].wrap), 12'(e[k].wrap));
        chk("new_high", k, 12'(act[k].new_high), 12'(e[k].new_high));
      end
    end
  end
  initial begin
    int r;
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    pulse_inc(12);
    idle(3);
    repeat (10) cyc(1, 0, 0, 0);
    idle(2);
    cyc(0, 0, 1, 0);
    pulse_inc(99);
    pulse_inc(1);
    pulse_dec(1);
    idle(1);
    cyc(0, 0, 1, 0);
    pulse_dec(3);
    idle(2);
    cyc(0, 0, 1, 0);
    pulse_inc(999);
    pulse_inc(1);
    idle(3);
    cyc(0, 0, 0, 1);
    pulse_inc(45);
    idle(3);
    cyc(0, 0, 1, 0);
    pulse_inc(45);
    idle(2);
    pulse_inc(1);
    idle(3);
    cyc(1, 1, 0, 0);
    idle(2);
    cyc(1, 0, 1, 0);
    idle(2);
    cyc(0, 0, 0, 1);
    pulse_inc(37);
    cyc(0, 0, 0, 1);
    idle(2);
    repeat (3000) begin
      r = $urandom_range(0, 99);
      cyc(1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, r < 2, r == 99);
    end
    idle(2);
    for (int t = 0; t < 10 && exp_q.size() != 0; t++) @(posedge clk);
    #2;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
